// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - complex sample type and add/sub/rotate helpers for the 4-point FFT
package fft_pkg;

  localparam int DATA_W = 16;

  // One complex point, packed {re, im} so it maps straight onto a 2*DATA_W bus.
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Component-wise sum, wrapping modulo 2^DATA_W.
  function automatic cplx_t cadd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  // Component-wise difference, wrapping modulo 2^DATA_W.
  function automatic cplx_t csub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

  // Multiply by -j: (re + j*im) * -j = im - j*re, so it is just a swap and negate.
  function automatic cplx_t mul_negj(input cplx_t a);
    cplx_t r;
    r.re = a.im;
    r.im = -a.re;
    return r;
  endfunction

endpackage

// File: rtl/fft_bf2.sv
// rtl/fft_bf2.sv - combinational radix-2 complex butterfly (p+q, p-q)
module fft_bf2
  import fft_pkg::*;
(
  input  cplx_t p,
  input  cplx_t q,
  output cplx_t sum,
  output cplx_t diff
);

  assign sum  = cadd(p, q);
  assign diff = csub(p, q);

endmodule

// File: rtl/fft4_radix2.sv
// rtl/fft4_radix2.sv - two-stage pipelined 4-point radix-2 DIT FFT, multiplier-free
module fft4_radix2
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2*DATA_W-1:0] in_point0,
  input  logic [2*DATA_W-1:0] in_point1,
  input  logic [2*DATA_W-1:0] in_point2,
  input  logic [2*DATA_W-1:0] in_point3,
  output logic [2*DATA_W-1:0] out_point0,
  output logic [2*DATA_W-1:0] out_point1,
  output logic [2*DATA_W-1:0] out_point2,
  output logic [2*DATA_W-1:0] out_point3
);

  cplx_t x0, x1, x2, x3;
  cplx_t a0_d, a1_d, b0_d, b1_d;
  cplx_t a0_q, a1_q, b0_q, b1_q;
  cplx_t b1_rot;
  cplx_t y0_d, y1_d, y2_d, y3_d;
  cplx_t y0_q, y1_q, y2_q, y3_q;

  assign x0 = in_point0;
  assign x1 = in_point1;
  assign x2 = in_point2;
  assign x3 = in_point3;

  // Stage 1: even/odd decimation, pairs (x0,x2) and (x1,x3).
  fft_bf2 u_bf_even (.p(x0), .q(x2), .sum(a0_d), .diff(a1_d));
  fft_bf2 u_bf_odd  (.p(x1), .q(x3), .sum(b0_d), .diff(b1_d));

  // Stage 2: the odd difference term carries the W4^1 = -j twiddle.
  assign b1_rot = mul_negj(b1_q);

  fft_bf2 u_bf_k02 (.p(a0_q), .q(b0_q),   .sum(y0_d), .diff(y2_d));
  fft_bf2 u_bf_k13 (.p(a1_q), .q(b1_rot), .sum(y1_d), .diff(y3_d));

  // Stage 1 register: captures the first butterfly layer on each enabled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a0_q <= '0;
      a1_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
    end else if (en) begin
      a0_q <= a0_d;
      a1_q <= a1_d;
      b0_q <= b0_d;
      b1_q <= b1_d;
    end
  end

  // Stage 2 register: holds the frequency bins that drive the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y0_q <= '0;
      y1_q <= '0;
      y2_q <= '0;
      y3_q <= '0;
    end else if (en) begin
      y0_q <= y0_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
      y3_q <= y3_d;
    end
  end

  assign out_point0 = y0_q;
  assign out_point1 = y1_q;
  assign out_point2 = y2_q;
  assign out_point3 = y3_q;

endmodule

// File: tb/tb_fft4_radix2.sv
// tb/tb_fft4_radix2.sv - scoreboard bench for fft4_radix2 against a direct DFT model
module tb_fft4_radix2;

  typedef logic [3:0][31:0] vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  vec_t cur_in = '0;
  logic [31:0] in_point0, in_point1, in_point2, in_point3;
  logic [31:0] out_point0, out_point1, out_point2, out_point3;

  int checks = 0;
  int errors = 0;

  vec_t exp_q[$];
  vec_t last_exp = '0;
  int   en_edges = 0;
  bit   edge_flag = 1'b0;

  assign in_point0 = cur_in[0];
  assign in_point1 = cur_in[1];
  assign in_point2 = cur_in[2];
  assign in_point3 = cur_in[3];

  fft4_radix2 dut (
    .clk(clk), .reset(reset), .en(en),
    .in_point0(in_point0), .in_point1(in_point1),
    .in_point2(in_point2), .in_point3(in_point3),
    .out_point0(out_point0), .out_point1(out_point1),
    .out_point2(out_point2), .out_point3(out_point3)
  );

  always #5 clk = ~clk;

  // Direct 4-point DFT, X[k] = sum x[n] * (-j)^(n*k), wrapped to 16 bits per component.
  function automatic vec_t dft4(input vec_t x);
    vec_t y;
    for (int k = 0; k < 4; k++) begin
      int sr, si;
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        int xr, xi;
        xr = signed'(x[n][31:16]);
        xi = signed'(x[n][15:0]);
        case ((n * k) % 4)
          0: begin sr += xr; si += xi; end
          1: begin sr += xi; si -= xr; end
          2: begin sr -= xr; si -= xi; end
          default: begin sr -= xi; si += xr; end
        endcase
      end
      y[k] = {sr[15:0], si[15:0]};
    end
    return y;
  endfunction

  function automatic vec_t outs();
    return {out_point3, out_point2, out_point1, out_point0};
  endfunction

  task automatic check(input string name, input vec_t got, input vec_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h_%h_%h_%h want %h_%h_%h_%h", name,
               got[0], got[1], got[2], got[3], want[0], want[1], want[2], want[3]);
    end
  endtask

  // Expected-response producer: every enabled edge queues the transform of the sampled inputs.
  always @(posedge clk) begin
    if (reset && en) begin
      exp_q.push_back(dft4(cur_in));
      en_edges++;
      edge_flag = 1'b1;
    end
  end

  // Asynchronous reset discards everything in flight.
  always @(negedge reset) begin
    exp_q.delete();
    en_edges  = 0;
    edge_flag = 1'b0;
  end

  // Monitor: compare outputs every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_zero", outs(), '0);
    end else if (en_edges < 2) begin
      check("fill_zero", outs(), '0);
    end else if (edge_flag) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got no entry want one");
      end else begin
        last_exp = exp_q.pop_front();
        check("pipe", outs(), last_exp);
      end
    end else begin
      check("hold", outs(), last_exp);
    end
    edge_flag = 1'b0;
  end

  function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3);
    return {p3, p2, p1, p0};
  endfunction

  task automatic run_vec(input string name, input vec_t v, input vec_t want);
    @(negedge clk);
    cur_in = v;
    en     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check(name, outs(), want);
  endtask

  task automatic random_cycles(input int n, input int en_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) cur_in[p] = $urandom;
      en = ($urandom_range(99) < en_pct);
    end
  endtask

  initial begin
    vec_t held;

    // Reset held with activity on the inputs.
    en = 1'b1;
    random_cycles(4, 100);
    @(negedge clk);
    reset = 1'b1;

    // Real vector and back-to-back pipelining.
    @(negedge clk);
    cur_in = mk(32'h00060000, 32'h00030000, 32'h00050000, 32'h00040000);
    en = 1'b1;
    @(negedge clk);
    cur_in = mk(32'h00100000, 32'h00250000, 32'h00050000, 32'h00090000);
    @(negedge clk);
    check("real_vec", outs(), mk(32'h00120000, 32'h00010001, 32'h00040000, 32'h0001FFFF));
    @(negedge clk);
    check("pipelined_vec", outs(), mk(32'h00430000, 32'h000BFFE4, 32'hFFE70000, 32'h000B001C));

    // Enable hold: five frozen cycles with changing inputs.
    held = outs();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) cur_in[p] = $urandom;
    end
    check("en_hold", outs(), held);

    // Impulses and wrap-around.
    run_vec("impulse_x0", mk(32'h00010000, 32'h0, 32'h0, 32'h0),
            mk(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000));
    run_vec("impulse_j_x1", mk(32'h0, 32'h00000001, 32'h0, 32'h0),
            mk(32'h00000001, 32'h00010000, 32'h0000FFFF, 32'hFFFF0000));
    run_vec("overflow_wrap", mk(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000),
            mk(32'h0, 32'h0, 32'h0, 32'h0));

    // Random traffic with sporadic enable.
    random_cycles(300, 70);

    // Asynchronous clear mid-cycle, then refill.
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_clear", outs(), '0);
    random_cycles(3, 100);
    @(negedge clk);
    reset = 1'b1;
    random_cycles(100, 60);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft4_radix2.md
Name: fft4_radix2

Overview:
- 4-point radix-2 DIT FFT on complex 16-bit fixed-point samples.
- Two-stage pipeline, advanced by a global enable.
- Sits between a sample-gathering front end and spectral post-processing.
- Twiddles for N=4 are only 1 and -j, so the block uses adders and swaps only, no multipliers.

Parameters:
- DATA_W, 16, width of each real/imag component; a point is 2*DATA_W bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance enable; all registers hold when 0.
- in_point0..in_point3  in  32 each  time-domain samples x0..x3; [31:16] real, [15:0] imag, signed two's complement.
- out_point0..out_point3  out  32 each  frequency bins X0..X3; same packing.

Behaviour:
- One clock, clk. reset is asynchronous and active-low.
- While reset=0: every pipeline register and out_point0..3 = 32'h0000_0000, immediately and independent of clk.
- Stage 1 register, loaded on a clk rising edge with en=1:
  - a0 = x0+x2, a1 = x0-x2
  - b0 = x1+x3, b1 = x1-x3
  - Add/sub is per component (real and imag separately).
- Stage 2 register, loaded on the same edges, drives the outputs:
  - X0 = a0+b0
  - X2 = a0-b0
  - X1.re = a1.re + b1.im, X1.im = a1.im - b1.re (a1 - j*b1)
  - X3.re = a1.re - b1.im, X3.im = a1.im + b1.re (a1 + j*b1)
- Latency: 2 enabled rising edges from input presentation to outputs.
- Throughput: one 4-point transform per enabled edge, fully pipelined.
- en=0: both stages hold; outputs stay stable. No bubbles are inserted; the pipeline freezes.
- No scaling: all arithmetic is DATA_W bits, wrapping modulo 2^DATA_W.
  - Overflow is silent; callers keep |x| small enough (up to 2 bits of growth).
- No valid or ready handshake. The consumer counts enabled edges.
- Reset asserted mid-operation: in-flight data is discarded. After release, outputs remain 0 until two enabled edges occur.
- Inputs are sampled only at enabled clk edges; changes between edges have no effect.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_W
  - a packed complex typedef {re, im}
  - functions cadd, csub, and mul_negj (returns {im, -re}).
- Natural sub-module: fft_bf2, a radix-2 complex butterfly.
  - Inputs p, q; outputs p+q and p-q; combinational.
  - Instantiated twice per stage. In stage 2, the second butterfly takes b1 rotated by -j.
- Registers live in the top.

Test Plan:
- Reset: hold reset=0, toggle clk with random inputs and en=1 -> all out_point = 0; also check async clear mid-cycle.
- Real vector: in = 0x00060000, 0x00030000, 0x00050000, 0x00040000, en=1, two edges -> out0=0x00120000, out1=0x00010001, out2=0x00040000, out3=0x0001FFFF.
- Pipelining: on the next edge, change in to 0x00100000, 0x00250000, 0x00050000, 0x00090000 -> one edge later outputs still show the previous vector. After the second edge: out0=0x00430000, out1=0x000BFFE4, out2=0xFFE70000, out3=0x000B001C.
- Enable hold: deassert en for 5 cycles while changing inputs -> outputs unchanged. After re-enable, the pipeline resumes with the previously held stage-1 contents emerging first.
- Complex/impulse: x0=0x00010000, others 0 -> all bins 0x00010000. x1=0x00000001 (j), others 0 -> X0=0x00000001, X1=0x00010000, X2=0x0000FFFF, X3=0xFFFF0000.
- Overflow wrap: all inputs 0x40000000 -> out0 real = 0x0000 (wrapped 4*0x4000), out1/out2/out3 = 0.
